// File: rtl/cmf_pkg.sv
// Shared types and constants for the per-pixel colour matrix filter.
// Holds the mode encoding plus default luma weights and sepia offsets.
package cmf_pkg;

    typedef enum logic [1:0] {
        CMF_BYPASS = 2'd0,
        CMF_GRAY   = 2'd1,
        CMF_SEPIA  = 2'd2,
        CMF_INVERT = 2'd3
    } cmf_mode_e;

    // BT.601-style luma weights scaled by 256
    localparam int CMF_DEF_CR = 77;
    localparam int CMF_DEF_CG = 150;
    localparam int CMF_DEF_CB = 29;

    localparam int CMF_TINT_R = 40;
    localparam int CMF_TINT_G = 20;
    localparam int CMF_TINT_B = -20;

endpackage

// File: rtl/color_matrix_filter_sat_clip.sv
// Signed-to-unsigned clamp: negative values go to 0, values above the
// output range go to all-ones, everything else passes through unchanged.
module sat_clip #(
    parameter int IN_W  = 12,
    parameter int OUT_W = 8
) (
    input  logic signed [IN_W-1:0] din,
    output logic        [OUT_W-1:0] dout
);

    localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

    // Clamp against both ends of the unsigned output range
    always_comb begin
        if (din[IN_W-1]) begin
            dout = {OUT_W{1'b0}};
        end else if (din > MAX_V) begin
            dout = {OUT_W{1'b1}};
        end else begin
            dout = din[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/color_matrix_filter.sv
// Three-stage per-pixel colour filter (bypass / grayscale / sepia / invert).
// Config is committed on frame_en and travels with each pixel down the pipe.
module color_matrix_filter #(
    parameter int PIX_W  = 8,
    parameter int COEF_W = 8,
    parameter int FRAC   = 8,
    parameter int SB_W   = 24,
    parameter int DEF_CR = cmf_pkg::CMF_DEF_CR,
    parameter int DEF_CG = cmf_pkg::CMF_DEF_CG,
    parameter int DEF_CB = cmf_pkg::CMF_DEF_CB,
    parameter int TINT_R = cmf_pkg::CMF_TINT_R,
    parameter int TINT_G = cmf_pkg::CMF_TINT_G,
    parameter int TINT_B = cmf_pkg::CMF_TINT_B
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_en,
    input  logic [1:0]        cfg_mode,
    input  logic [COEF_W-1:0] cfg_cr,
    input  logic [COEF_W-1:0] cfg_cg,
    input  logic [COEF_W-1:0] cfg_cb,
    input  logic              in_valid,
    input  logic [PIX_W-1:0]  in_R,
    input  logic [PIX_W-1:0]  in_G,
    input  logic [PIX_W-1:0]  in_B,
    input  logic [SB_W-1:0]   pass_in,
    output logic              out_valid,
    output logic [PIX_W-1:0]  out_R,
    output logic [PIX_W-1:0]  out_G,
    output logic [PIX_W-1:0]  out_B,
    output logic [SB_W-1:0]   pass_thru
);

    import cmf_pkg::*;

    localparam int PROD_W = PIX_W + COEF_W;
    localparam int SUM_W  = PROD_W + 2;
    localparam int Y_W    = SUM_W - FRAC;
    localparam int EXT_W  = ((Y_W > PIX_W + 1) ? Y_W : PIX_W + 1) + 2;

    localparam logic signed [PIX_W:0] TINT_R_C = (PIX_W+1)'(TINT_R);
    localparam logic signed [PIX_W:0] TINT_G_C = (PIX_W+1)'(TINT_G);
    localparam logic signed [PIX_W:0] TINT_B_C = (PIX_W+1)'(TINT_B);
    localparam logic [PIX_W-1:0]      PIX_MAX  = {PIX_W{1'b1}};

    cmf_mode_e         act_mode_r;
    logic [COEF_W-1:0] act_cr_r, act_cg_r, act_cb_r;

    cmf_mode_e         sel_mode_s;
    logic [COEF_W-1:0] sel_cr_s, sel_cg_s, sel_cb_s;

    logic              s1_valid_r;
    logic [SB_W-1:0]   s1_sb_r;
    cmf_mode_e         s1_mode_r;
    logic [PROD_W-1:0] s1_pr_r, s1_pg_r, s1_pb_r;
    logic [PIX_W-1:0]  s1_r_r, s1_g_r, s1_b_r;

    logic [SUM_W-1:0]  sum_s;

    logic              s2_valid_r;
    logic [SB_W-1:0]   s2_sb_r;
    cmf_mode_e         s2_mode_r;
    logic [Y_W-1:0]    s2_y_r;
    logic [PIX_W-1:0]  s2_r_r, s2_g_r, s2_b_r;

    logic signed [EXT_W-1:0] y_ext_s;
    logic signed [EXT_W-1:0] tint_r_s, tint_g_s, tint_b_s;
    logic signed [EXT_W-1:0] clip_r_s, clip_g_s, clip_b_s;
    logic [PIX_W-1:0]        sat_r_s, sat_g_s, sat_b_s;
    logic [PIX_W-1:0]        mux_r_s, mux_g_s, mux_b_s;

    // Active config registers, reloaded on every frame_en edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            act_mode_r <= CMF_BYPASS;
            act_cr_r   <= COEF_W'(DEF_CR);
            act_cg_r   <= COEF_W'(DEF_CG);
            act_cb_r   <= COEF_W'(DEF_CB);
        end else if (frame_en) begin
            act_mode_r <= cmf_mode_e'(cfg_mode);
            act_cr_r   <= cfg_cr;
            act_cg_r   <= cfg_cg;
            act_cb_r   <= cfg_cb;
        end else begin
            act_mode_r <= act_mode_r;
            act_cr_r   <= act_cr_r;
            act_cg_r   <= act_cg_r;
            act_cb_r   <= act_cb_r;
        end
    end

    // The pixel accepted on a commit edge already sees the incoming config
    always_comb begin
        if (frame_en) begin
            sel_mode_s = cmf_mode_e'(cfg_mode);
            sel_cr_s   = cfg_cr;
            sel_cg_s   = cfg_cg;
            sel_cb_s   = cfg_cb;
        end else begin
            sel_mode_s = act_mode_r;
            sel_cr_s   = act_cr_r;
            sel_cg_s   = act_cg_r;
            sel_cb_s   = act_cb_r;
        end
    end

    // Stage 1: weighted products, raw pixel and per-pixel mode
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_r <= 1'b0;
            s1_sb_r    <= {SB_W{1'b0}};
            s1_mode_r  <= CMF_BYPASS;
            s1_pr_r    <= {PROD_W{1'b0}};
            s1_pg_r    <= {PROD_W{1'b0}};
            s1_pb_r    <= {PROD_W{1'b0}};
            s1_r_r     <= {PIX_W{1'b0}};
            s1_g_r     <= {PIX_W{1'b0}};
            s1_b_r     <= {PIX_W{1'b0}};
        end else begin
            s1_valid_r <= in_valid;
            s1_sb_r    <= pass_in;
            s1_mode_r  <= sel_mode_s;
            s1_pr_r    <= PROD_W'(in_R) * PROD_W'(sel_cr_s);
            s1_pg_r    <= PROD_W'(in_G) * PROD_W'(sel_cg_s);
            s1_pb_r    <= PROD_W'(in_B) * PROD_W'(sel_cb_s);
            s1_r_r     <= in_R;
            s1_g_r     <= in_G;
            s1_b_r     <= in_B;
        end
    end

    assign sum_s = SUM_W'(s1_pr_r) + SUM_W'(s1_pg_r) + SUM_W'(s1_pb_r);

    // Stage 2: luma by truncating shift of the weighted sum
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid_r <= 1'b0;
            s2_sb_r    <= {SB_W{1'b0}};
            s2_mode_r  <= CMF_BYPASS;
            s2_y_r     <= {Y_W{1'b0}};
            s2_r_r     <= {PIX_W{1'b0}};
            s2_g_r     <= {PIX_W{1'b0}};
            s2_b_r     <= {PIX_W{1'b0}};
        end else begin
            s2_valid_r <= s1_valid_r;
            s2_sb_r    <= s1_sb_r;
            s2_mode_r  <= s1_mode_r;
            s2_y_r     <= Y_W'(sum_s >> FRAC);
            s2_r_r     <= s1_r_r;
            s2_g_r     <= s1_g_r;
            s2_b_r     <= s1_b_r;
        end
    end

    // Grayscale shares the clamp path with sepia using a zero offset
    always_comb begin
        y_ext_s = EXT_W'($signed({1'b0, s2_y_r}));
        if (s2_mode_r == CMF_SEPIA) begin
            tint_r_s = EXT_W'(TINT_R_C);
            tint_g_s = EXT_W'(TINT_G_C);
            tint_b_s = EXT_W'(TINT_B_C);
        end else begin
            tint_r_s = {EXT_W{1'b0}};
            tint_g_s = {EXT_W{1'b0}};
            tint_b_s = {EXT_W{1'b0}};
        end
        clip_r_s = y_ext_s + tint_r_s;
        clip_g_s = y_ext_s + tint_g_s;
        clip_b_s = y_ext_s + tint_b_s;
    end

    sat_clip #(.IN_W(EXT_W), .OUT_W(PIX_W)) u_sat_r (.din(clip_r_s), .dout(sat_r_s));
    sat_clip #(.IN_W(EXT_W), .OUT_W(PIX_W)) u_sat_g (.din(clip_g_s), .dout(sat_g_s));
    sat_clip #(.IN_W(EXT_W), .OUT_W(PIX_W)) u_sat_b (.din(clip_b_s), .dout(sat_b_s));

    // Stage 3 output select by the mode carried with the pixel
    always_comb begin
        mux_r_s = s2_r_r;
        mux_g_s = s2_g_r;
        mux_b_s = s2_b_r;
        case (s2_mode_r)
            CMF_BYPASS: begin
                mux_r_s = s2_r_r;
                mux_g_s = s2_g_r;
                mux_b_s = s2_b_r;
            end
            CMF_GRAY, CMF_SEPIA: begin
                mux_r_s = sat_r_s;
                mux_g_s = sat_g_s;
                mux_b_s = sat_b_s;
            end
            CMF_INVERT: begin
                mux_r_s = PIX_MAX - s2_r_r;
                mux_g_s = PIX_MAX - s2_g_r;
                mux_b_s = PIX_MAX - s2_b_r;
            end
            default: begin
                mux_r_s = s2_r_r;
                mux_g_s = s2_g_r;
                mux_b_s = s2_b_r;
            end
        endcase
    end

    // Output registers; pixel data holds across bubbles, sideband always flows
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_R     <= {PIX_W{1'b0}};
            out_G     <= {PIX_W{1'b0}};
            out_B     <= {PIX_W{1'b0}};
            pass_thru <= {SB_W{1'b0}};
        end else begin
            out_valid <= s2_valid_r;
            pass_thru <= s2_sb_r;
            if (s2_valid_r) begin
                out_R <= mux_r_s;
                out_G <= mux_g_s;
                out_B <= mux_b_s;
            end else begin
                out_R <= out_R;
                out_G <= out_G;
                out_B <= out_B;
            end
        end
    end

endmodule

// File: tb/tb_color_matrix_filter.sv
// Scoreboard bench for color_matrix_filter: stimulus pushes hand-computed
// expectations, a negedge monitor pops and compares on every out_valid.
module tb_color_matrix_filter;

    logic        clk;
    logic        rst;
    logic        frame_en;
    logic [1:0]  cfg_mode;
    logic [7:0]  cfg_cr, cfg_cg, cfg_cb;
    logic        in_valid;
    logic [7:0]  in_R, in_G, in_B;
    logic [23:0] pass_in;
    logic        out_valid;
    logic [7:0]  out_R, out_G, out_B;
    logic [23:0] pass_thru;

    color_matrix_filter dut (
        .clk(clk), .rst(rst), .frame_en(frame_en), .cfg_mode(cfg_mode),
        .cfg_cr(cfg_cr), .cfg_cg(cfg_cg), .cfg_cb(cfg_cb),
        .in_valid(in_valid), .in_R(in_R), .in_G(in_G), .in_B(in_B),
        .pass_in(pass_in), .out_valid(out_valid),
        .out_R(out_R), .out_G(out_G), .out_B(out_B), .pass_thru(pass_thru)
    );

    typedef struct {
        logic [47:0] data;
        int          issue;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every presented output must match the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b1 && out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_out: got %0h with nothing expected",
                         {out_R, out_G, out_B, pass_thru});
            end else begin
                e = sb_q.pop_front();
                check("pixel", {16'd0, out_R, out_G, out_B, pass_thru}, {16'd0, e.data});
                check("latency", 64'(cyc - e.issue), 64'd3);
            end
        end
    end

    task automatic send(input logic [7:0] r, g, b, input logic [23:0] sbd,
                        input logic fe, input logic [1:0] mode,
                        input logic [7:0] cr, cg, cb,
                        input logic [7:0] er, eg, eb);
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        in_R = r; in_G = g; in_B = b; pass_in = sbd;
        frame_en = fe; cfg_mode = mode; cfg_cr = cr; cfg_cg = cg; cfg_cb = cb;
        e.data  = {er, eg, eb, sbd};
        e.issue = cyc;
        sb_q.push_back(e);
    endtask

    task automatic commit(input logic [1:0] mode, input logic [7:0] cr, cg, cb);
        @(negedge clk);
        in_valid = 1'b0;
        frame_en = 1'b1; cfg_mode = mode; cfg_cr = cr; cfg_cg = cg; cfg_cb = cb;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            frame_en = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b0;
        frame_en = 1'b0; cfg_mode = 2'd0;
        cfg_cr = 8'd0; cfg_cg = 8'd0; cfg_cb = 8'd0;
        in_valid = 1'b0; in_R = 8'd0; in_G = 8'd0; in_B = 8'd0; pass_in = 24'd0;
        repeat (3) @(negedge clk);
        check("reset_valid", 64'(out_valid), 64'd0);
        check("reset_pixel", 64'({out_R, out_G, out_B}), 64'd0);
        check("reset_sb", 64'(pass_thru), 64'd0);
        rst = 1'b1;
        idle(2);

        // Bypass after reset uses the reset mode
        send(8'd100, 8'd50, 8'd200, 24'hABCDEF, 1'b0, 2'd0, 8'd0, 8'd0, 8'd0,
             8'd100, 8'd50, 8'd200);
        idle(6);
        check("hold_pixel", 64'({out_R, out_G, out_B}), 64'({8'd100, 8'd50, 8'd200}));

        // Grayscale, committed on a bubble
        commit(2'd1, 8'd77, 8'd150, 8'd29);
        send(8'd100, 8'd50, 8'd200, 24'h000001, 1'b0, 2'd0, 8'd0, 8'd0, 8'd0,
             8'd82, 8'd82, 8'd82);
        send(8'd255, 8'd255, 8'd255, 24'h000002, 1'b0, 2'd0, 8'd0, 8'd0, 8'd0,
             8'd255, 8'd255, 8'd255);
        idle(5);

        // Sepia, including clamp at zero on blue
        commit(2'd2, 8'd77, 8'd150, 8'd29);
        send(8'd100, 8'd50, 8'd200, 24'h000003, 1'b0, 2'd0, 8'd0, 8'd0, 8'd0,
             8'd122, 8'd102, 8'd62);
        send(8'd10, 8'd10, 8'd10, 24'h000004, 1'b0, 2'd0, 8'd0, 8'd0, 8'd0,
             8'd50, 8'd30, 8'd0);
        idle(5);

        // Saturation: Y=762 and Y=348 both clamp to 255
        commit(2'd1, 8'd255, 8'd255, 8'd255);
        send(8'd255, 8'd255, 8'd255, 24'h000005, 1'b0, 2'd0, 8'd0, 8'd0, 8'd0,
             8'd255, 8'd255, 8'd255);
        send(8'd100, 8'd50, 8'd200, 24'h000006, 1'b0, 2'd0, 8'd0, 8'd0, 8'd0,
             8'd255, 8'd255, 8'd255);
        idle(5);

        // Invert stream with a gray commit on the third pixel
        commit(2'd3, 8'd77, 8'd150, 8'd29);
        send(8'd100, 8'd50, 8'd200, 24'h000011, 1'b0, 2'd0, 8'd0, 8'd0, 8'd0,
             8'd155, 8'd205, 8'd55);
        send(8'd100, 8'd50, 8'd200, 24'h000012, 1'b0, 2'd0, 8'd0, 8'd0, 8'd0,
             8'd155, 8'd205, 8'd55);
        send(8'd100, 8'd50, 8'd200, 24'h000013, 1'b1, 2'd1, 8'd77, 8'd150, 8'd29,
             8'd82, 8'd82, 8'd82);
        send(8'd100, 8'd50, 8'd200, 24'h000014, 1'b0, 2'd0, 8'd0, 8'd0, 8'd0,
             8'd82, 8'd82, 8'd82);
        idle(5);

        // Back-to-back commits: the last one (bypass) wins over sepia
        commit(2'd2, 8'd77, 8'd150, 8'd29);
        commit(2'd0, 8'd77, 8'd150, 8'd29);
        send(8'd100, 8'd50, 8'd200, 24'h000021, 1'b0, 2'd0, 8'd0, 8'd0, 8'd0,
             8'd100, 8'd50, 8'd200);
        idle(5);

        // Async reset with the pipe full of inverted pixels
        commit(2'd3, 8'd77, 8'd150, 8'd29);
        for (int i = 0; i < 4; i++) begin
            send(8'd100, 8'd50, 8'd200, 24'h000030 + 24'(i), 1'b0, 2'd0, 8'd0, 8'd0, 8'd0,
                 8'd155, 8'd205, 8'd55);
        end
        @(posedge clk);
        #1;
        check("prereset_valid", 64'(out_valid), 64'd1);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        frame_en = 1'b0;
        #1;
        check("async_valid", 64'(out_valid), 64'd0);
        check("async_pixel", 64'({out_R, out_G, out_B}), 64'd0);
        check("async_sb", 64'(pass_thru), 64'd0);
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        idle(1);
        send(8'd100, 8'd50, 8'd200, 24'h000040, 1'b0, 2'd0, 8'd0, 8'd0, 8'd0,
             8'd100, 8'd50, 8'd200);
        idle(1);

        begin
            int waited;
            waited = 0;
            while (sb_q.size() != 0 && waited < 20) begin
                @(negedge clk);
                waited++;
            end
            check("drain", 64'(sb_q.size()), 64'd0);
        end
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
